time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 30, edit-inactivity abort limit in clk cycles.
REQ-002 SHALL have parameter REPEAT_DELAY, default 2, hold cycles before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 1, cycles between auto-repeat steps.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- btn_mode  in  1  advance field / commit; debounced level
- btn_inc  in  1  increment field; debounced level
- btn_dec  in  1  decrement field; debounced level
- btn_cancel  in  1  abort edit; debounced level
- cur_hr24 / cur_min / cur_sec  in  5/6/6  live clock time
- cur_day / cur_month / cur_year  in  5/4/7  live date; year 0-99
- editing  out  1  high in any EDIT or COMMIT state
- edit_field  out  3  0 = none, 1 = HR, 2 = MIN, 3 = SEC, 4 = DAY, 5 = MONTH, 6 = YEAR
- set_hr24 / set_min / set_sec / set_day / set_month / set_year  out  5/6/6/5/4/7  working values
- load_valid  out  1  commit request to the clock
- load_ready  in  1  clock accepts the load

Function
REQ-005 SHALL register every button and act only on its rising edge (level high now, low last cycle); action is visible on outputs one cycle after the edge is sampled.
REQ-006 SHALL implement states IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, EDIT_DAY, EDIT_MONTH, EDIT_YEAR and COMMIT.
REQ-007 IDLE + mode edge SHALL snapshot all cur_* inputs into set_* and go to EDIT_HR.
REQ-008 A mode edge in EDIT_x SHALL advance to the next field in the order HR, MIN, SEC, DAY, MONTH, YEAR, then COMMIT.
REQ-009 COMMIT SHALL assert load_valid and hold set_* stable until a cycle with load_ready=1, then go to IDLE with load_valid=0 on the next cycle.
REQ-010 A cancel edge in any EDIT state SHALL go to IDLE without asserting load_valid; cancel is ignored in COMMIT and IDLE.
REQ-011 An inc or dec step SHALL change only the current field, with wrap-around:
- HR 0-23
- MIN and SEC 0-59
- DAY 1 to month length
- MONTH 1-12
- YEAR 0-99
REQ-012 Month length SHALL be 28 for February, 30 for April, June, September and November, and 31 otherwise; there is no leap year.
REQ-013 When the month or the snapshot changes and the day exceeds the new month length, the day SHALL clamp to the month length in the same cycle.
REQ-014 Simultaneous inc and dec edges SHALL leave the field unchanged; a mode edge together with inc/dec SHALL apply the step first, then advance.
REQ-015 An inactivity counter SHALL reset on any button edge; reaching TIMEOUT_CYCLES in an EDIT state SHALL abort to IDLE with no load; COMMIT has no timeout.
REQ-016 In IDLE, editing=0 and edit_field=0, and set_* SHALL track cur_* every cycle.

Reset
REQ-017 rst SHALL immediately force:
- IDLE, editing=0, edit_field=0, load_valid=0
- set_* = 0:00:00, 01/01/20
- all counters and edge registers cleared
REQ-018 rst mid-edit or mid-COMMIT SHALL discard the edit and the pending load.

Configuration
REQ-019 With AUTO_REPEAT_EN defined, holding inc or dec for REPEAT_DELAY cycles after its edge SHALL generate one extra step every REPEAT_PERIOD cycles while held, and each repeat step SHALL reset the timeout.
REQ-020 Without AUTO_REPEAT_EN, only rising edges SHALL step, and REPEAT_DELAY and REPEAT_PERIOD SHALL have no effect.

Structure
REQ-021 A shared package SHALL hold:
- the state enum and edit_field encodings
- field min/max constants
- the month-length function
REQ-022 A sub-module btn_edge SHALL provide the edge register and the optional hold/repeat counter, instantiated once per button.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Snapshot and commit: cur = 12:14:00, 05/03/2025; mode edge; 5 inc edges in HR; mode x6; load_ready=1 -> load_valid for one cycle with set_hr24=17 and the other fields unchanged.
- Hour wrap and month clamp: HR=23 + inc -> 0; DAY=31, MONTH=1 + inc -> MONTH=2, DAY=28; MONTH=12 + inc -> 1.
- Down wrap: YEAR=0 + dec -> 99; MIN=0 + dec -> 59.
- Cancel and timeout: cancel in EDIT_SEC -> IDLE with no load_valid; no buttons for 30 cycles in EDIT_MIN -> IDLE with no load.
- Handshake: load_ready low for 5 cycles in COMMIT -> load_valid and set_* stable throughout; rst asserted in cycle 3 -> load_valid=0 immediately.
- AUTO_REPEAT_EN: inc held 10 cycles on MIN=0 with delay 2, period 1 -> MIN=9 (1 edge step + 8 repeat steps).

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// Shared types, field limits and calendar helpers for the time/date setting controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package time_set_ctrl_pkg;

    // State values 1..6 line up with the edit_field encoding of the field being edited
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EDIT_HR    = 3'd1,
        EDIT_MIN   = 3'd2,
        EDIT_SEC   = 3'd3,
        EDIT_DAY   = 3'd4,
        EDIT_MONTH = 3'd5,
        EDIT_YEAR  = 3'd6,
        COMMIT     = 3'd7
    } state_t;

    localparam logic [2:0] FIELD_NONE  = 3'd0;
    localparam logic [2:0] FIELD_HR    = 3'd1;
    localparam logic [2:0] FIELD_MIN   = 3'd2;
    localparam logic [2:0] FIELD_SEC   = 3'd3;
    localparam logic [2:0] FIELD_DAY   = 3'd4;
    localparam logic [2:0] FIELD_MONTH = 3'd5;
    localparam logic [2:0] FIELD_YEAR  = 3'd6;

    // Field limits, all held at the width of the generic step helper
    localparam logic [6:0] ZERO_MIN  = 7'd0;
    localparam logic [6:0] HR_MAX    = 7'd23;
    localparam logic [6:0] MIN_MAX   = 7'd59;
    localparam logic [6:0] SEC_MAX   = 7'd59;
    localparam logic [6:0] DAY_MIN   = 7'd1;
    localparam logic [6:0] MONTH_MIN = 7'd1;
    localparam logic [6:0] MONTH_MAX = 7'd12;
    localparam logic [6:0] YEAR_MAX  = 7'd99;

    // Values loaded into the working registers by reset: 0:00:00, 01/01/20
    localparam logic [4:0] RST_DAY   = 5'd1;
    localparam logic [3:0] RST_MONTH = 4'd1;
    localparam logic [6:0] RST_YEAR  = 7'd20;

    // Days in a month; no leap years, so February is always 28
    function automatic logic [4:0] month_len(input logic [3:0] month);
        logic [4:0] len;
        case (month)
            4'd2:                       len = 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:    len = 5'd30;
            default:                    len = 5'd31;
        endcase
        return len;
    endfunction

    // One up or down step inside [lo, hi] with wrap-around; no step leaves the value alone
    function automatic logic [6:0] wrap_step(input logic [6:0] val, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up,
                                             input logic dn);
        logic [6:0] res;
        res = val;
        if (up) begin
            res = (val >= hi) ? lo : val + 7'd1;
        end else if (dn) begin
            res = (val <= lo) ? hi : val - 7'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Button front end: registers a debounced level and emits one step pulse per rising edge.
// Latency: step pulse is high the cycle after the press is first sampled; with AUTO_REPEAT_EN
//          defined, a held button adds a step after REPEAT_DELAY cycles and then every REPEAT_PERIOD.
// Backpressure: none; the pulse is consumed the cycle it is high.
module btn_edge #(
    parameter int REPEAT_DELAY  = 2,
    parameter int REPEAT_PERIOD = 1,
    parameter bit HOLD_REPEAT   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic step
);

    logic btn_r;
    logic btn_prev;
    logic rise;

    // Sample the level, and keep last cycle's sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_r    <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_r    <= btn;
            btn_prev <= btn_r;
        end
    end

    assign rise = btn_r & ~btn_prev;

`ifdef AUTO_REPEAT_EN
    // Cycles left until the next repeat step while the button stays held (delay assumed >= 1)
    logic [15:0] rep_cnt;
    logic        held;
    logic        rep_fire;

    assign held     = btn_r & btn_prev;
    assign rep_fire = HOLD_REPEAT && held && (rep_cnt == 16'd0);

    // Load the initial delay on the edge, then reload with the period after each repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= 16'd0;
        end else if (rise) begin
            rep_cnt <= 16'(REPEAT_DELAY - 1);
        end else if (held) begin
            rep_cnt <= (rep_cnt == 16'd0) ? 16'(REPEAT_PERIOD - 1) : rep_cnt - 16'd1;
        end else begin
            rep_cnt <= 16'd0;
        end
    end

    assign step = rise | rep_fire;
`else
    // Repeat timing has no meaning in this build; fold it into a deliberately unused net
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, HOLD_REPEAT};

    assign step = rise;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Time/date setting controller: snapshot live time, edit field by field, hand result to the clock.
// Latency: a button acts one cycle after its edge is sampled; optional AUTO_REPEAT_EN adds hold-repeat.
// Backpressure: COMMIT holds load_valid and set_* stable until load_ready; no edit timeout there.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int REPEAT_DELAY   = 2,
    parameter int REPEAT_PERIOD  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_cancel,
    input  logic [4:0] cur_hr24,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] cur_day,
    input  logic [3:0] cur_month,
    input  logic [6:0] cur_year,
    output logic       editing,
    output logic [2:0] edit_field,
    output logic [4:0] set_hr24,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic [4:0] set_day,
    output logic [3:0] set_month,
    output logic [6:0] set_year,
    output logic       load_valid,
    input  logic       load_ready
);

    state_t      state, state_nxt;
    logic        mode_step, inc_step, dec_step, cancel_step;
    logic        up, dn, activity, in_edit, timeout;
    logic [15:0] idle_cnt;
    logic [4:0]  nxt_hr, nxt_day, snap_len, new_len;
    logic [5:0]  nxt_min, nxt_sec;
    logic [3:0]  nxt_month;
    logic [6:0]  nxt_year;

    btn_edge #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .HOLD_REPEAT(1'b0))
        u_mode   (.clk(clk), .rst(rst), .btn(btn_mode),   .step(mode_step));
    btn_edge #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .HOLD_REPEAT(1'b1))
        u_inc    (.clk(clk), .rst(rst), .btn(btn_inc),    .step(inc_step));
    btn_edge #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .HOLD_REPEAT(1'b1))
        u_dec    (.clk(clk), .rst(rst), .btn(btn_dec),    .step(dec_step));
    btn_edge #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .HOLD_REPEAT(1'b0))
        u_cancel (.clk(clk), .rst(rst), .btn(btn_cancel), .step(cancel_step));

    // Opposing steps in the same cycle cancel out
    assign up       = inc_step & ~dec_step;
    assign dn       = dec_step & ~inc_step;
    assign activity = mode_step | inc_step | dec_step | cancel_step;
    assign in_edit  = (state != IDLE) && (state != COMMIT);
    assign timeout  = in_edit && !activity && (idle_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Inactivity counter: cleared by any step and whenever not editing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= 16'd0;
        end else if (!in_edit || activity) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: cancel beats mode, timeout only when nothing was pressed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (mode_step) state_nxt = EDIT_HR;
            COMMIT:     if (load_ready) state_nxt = IDLE;
            default: begin
                if (cancel_step || timeout) begin
                    state_nxt = IDLE;
                end else if (mode_step) begin
                    case (state)
                        EDIT_HR:    state_nxt = EDIT_MIN;
                        EDIT_MIN:   state_nxt = EDIT_SEC;
                        EDIT_SEC:   state_nxt = EDIT_DAY;
                        EDIT_DAY:   state_nxt = EDIT_MONTH;
                        EDIT_MONTH: state_nxt = EDIT_YEAR;
                        default:    state_nxt = COMMIT;
                    endcase
                end
            end
        endcase
    end

    // Outputs decoded from the state alone
    always_comb begin
        editing    = (state != IDLE);
        load_valid = (state == COMMIT);
        edit_field = FIELD_NONE;
        case (state)
            EDIT_HR:    edit_field = FIELD_HR;
            EDIT_MIN:   edit_field = FIELD_MIN;
            EDIT_SEC:   edit_field = FIELD_SEC;
            EDIT_DAY:   edit_field = FIELD_DAY;
            EDIT_MONTH: edit_field = FIELD_MONTH;
            EDIT_YEAR:  edit_field = FIELD_YEAR;
            default:    edit_field = FIELD_NONE;
        endcase
    end

    // Working values: track live time in IDLE, step the active field, freeze in COMMIT
    always_comb begin
        nxt_hr    = set_hr24;
        nxt_min   = set_min;
        nxt_sec   = set_sec;
        nxt_day   = set_day;
        nxt_month = set_month;
        nxt_year  = set_year;
        snap_len  = month_len(cur_month);
        new_len   = month_len(set_month);
        case (state)
            IDLE: begin
                nxt_hr    = cur_hr24;
                nxt_min   = cur_min;
                nxt_sec   = cur_sec;
                nxt_month = cur_month;
                nxt_year  = cur_year;
                nxt_day   = (cur_day > snap_len) ? snap_len : cur_day;
            end
            EDIT_HR:  nxt_hr  = 5'(wrap_step({2'b0, set_hr24}, ZERO_MIN, HR_MAX, up, dn));
            EDIT_MIN: nxt_min = 6'(wrap_step({1'b0, set_min}, ZERO_MIN, MIN_MAX, up, dn));
            EDIT_SEC: nxt_sec = 6'(wrap_step({1'b0, set_sec}, ZERO_MIN, SEC_MAX, up, dn));
            EDIT_DAY: nxt_day = 5'(wrap_step({2'b0, set_day}, DAY_MIN, {2'b0, new_len}, up, dn));
            EDIT_MONTH: begin
                nxt_month = 4'(wrap_step({3'b0, set_month}, MONTH_MIN, MONTH_MAX, up, dn));
                new_len   = month_len(nxt_month);
                nxt_day   = (set_day > new_len) ? new_len : set_day;
            end
            EDIT_YEAR: nxt_year = wrap_step(set_year, ZERO_MIN, YEAR_MAX, up, dn);
            default: begin
            end
        endcase
    end

    // Working value registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_hr24  <= 5'd0;
            set_min   <= 6'd0;
            set_sec   <= 6'd0;
            set_day   <= RST_DAY;
            set_month <= RST_MONTH;
            set_year  <= RST_YEAR;
        end else begin
            set_hr24  <= nxt_hr;
            set_min   <= nxt_min;
            set_sec   <= nxt_sec;
            set_day   <= nxt_day;
            set_month <= nxt_month;
            set_year  <= nxt_year;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: snapshot/commit, wraps, clamp, cancel, timeout, handshake, reset.
// Latency: presses are a one-cycle pulse; the effect is checked after the following clock.
// Backpressure: load_ready is driven directly to exercise the COMMIT hold.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_inc, btn_dec, btn_cancel;
    logic [4:0] cur_hr24, cur_day;
    logic [5:0] cur_min, cur_sec;
    logic [3:0] cur_month;
    logic [6:0] cur_year;
    logic       editing, load_valid, load_ready;
    logic [2:0] edit_field;
    logic [4:0] set_hr24, set_day;
    logic [5:0] set_min, set_sec;
    logic [3:0] set_month;
    logic [6:0] set_year;

    int   n_checks = 0;
    int   n_errors = 0;
    logic lv_seen  = 1'b0;

    time_set_ctrl #(.TIMEOUT_CYCLES(30), .REPEAT_DELAY(2), .REPEAT_PERIOD(1)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
        .cur_hr24(cur_hr24), .cur_min(cur_min), .cur_sec(cur_sec),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .editing(editing), .edit_field(edit_field),
        .set_hr24(set_hr24), .set_min(set_min), .set_sec(set_sec),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .load_valid(load_valid), .load_ready(load_ready)
    );

    always #5 clk = ~clk;

    // Remember any load request seen, sampled away from the active edge
    always @(negedge clk) begin
        if (load_valid === 1'b1) lv_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the selected buttons, then one more clock for the action to land
    task automatic press(input logic m, input logic i, input logic d, input logic c);
        btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
        tick();
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
        tick();
    endtask

    task automatic set_cur(input int h, input int mi, input int s, input int d, input int mo,
                           input int y);
        cur_hr24 = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
        cur_day = 5'(d); cur_month = 4'(mo); cur_year = 7'(y);
    endtask

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
        load_ready = 1'b0;
        set_cur(12, 14, 0, 5, 3, 25);
        tick(); tick();

        // Reset state
        check("rst_editing", 32'(editing), 0);
        check("rst_field", 32'(edit_field), 0);
        check("rst_load_valid", 32'(load_valid), 0);
        check("rst_hr", 32'(set_hr24), 0);
        check("rst_min", 32'(set_min), 0);
        check("rst_day", 32'(set_day), 1);
        check("rst_month", 32'(set_month), 1);
        check("rst_year", 32'(set_year), 20);
        rst = 1'b0;
        tick();
        check("idle_track_hr", 32'(set_hr24), 12);
        check("idle_track_day", 32'(set_day), 5);

        // Snapshot, +5 hours, walk all fields, commit with load_ready already high
        load_ready = 1'b1;
        press(1, 0, 0, 0);
        check("snap_editing", 32'(editing), 1);
        check("snap_field", 32'(edit_field), 1);
        check("snap_hr", 32'(set_hr24), 12);
        repeat (5) press(0, 1, 0, 0);
        check("inc5_hr", 32'(set_hr24), 17);
        repeat (5) press(1, 0, 0, 0);
        check("walk_field_year", 32'(edit_field), 6);
        press(1, 0, 0, 0);
        check("commit_lv", 32'(load_valid), 1);
        check("commit_field", 32'(edit_field), 0);
        check("commit_hr", 32'(set_hr24), 17);
        check("commit_min", 32'(set_min), 14);
        check("commit_sec", 32'(set_sec), 0);
        check("commit_day", 32'(set_day), 5);
        check("commit_month", 32'(set_month), 3);
        check("commit_year", 32'(set_year), 25);
        tick();
        check("commit_lv_drop", 32'(load_valid), 0);
        check("commit_idle", 32'(editing), 0);

        // Hour wrap, combined mode+inc, minute down-wrap, month clamp and wrap, year down-wrap
        load_ready = 1'b0;
        set_cur(23, 0, 0, 31, 1, 0);
        tick();
        press(1, 0, 0, 0);
        check("wrap_hr_start", 32'(set_hr24), 23);
        press(0, 1, 0, 0);
        check("wrap_hr", 32'(set_hr24), 0);
        press(1, 1, 0, 0);
        check("mode_inc_hr", 32'(set_hr24), 1);
        check("mode_inc_field", 32'(edit_field), 2);
        press(0, 0, 1, 0);
        check("wrap_min_down", 32'(set_min), 59);
        repeat (3) press(1, 0, 0, 0);
        check("month_field", 32'(edit_field), 5);
        press(0, 1, 0, 0);
        check("feb_month", 32'(set_month), 2);
        check("feb_clamp_day", 32'(set_day), 28);
        repeat (10) press(0, 1, 0, 0);
        check("dec_month", 32'(set_month), 12);
        check("dec_day_kept", 32'(set_day), 28);
        press(0, 1, 0, 0);
        check("wrap_month", 32'(set_month), 1);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        check("wrap_year_down", 32'(set_year), 99);
        press(0, 1, 1, 0);
        check("inc_dec_same", 32'(set_year), 99);
        press(0, 0, 0, 1);
        check("cancel_year", 32'(editing), 0);

        // Cancel in EDIT_SEC, then return to live tracking
        set_cur(8, 30, 45, 10, 6, 24);
        tick();
        lv_seen = 1'b0;
        repeat (3) press(1, 0, 0, 0);
        check("sec_field", 32'(edit_field), 3);
        press(0, 0, 0, 1);
        check("cancel_editing", 32'(editing), 0);
        check("cancel_field", 32'(edit_field), 0);
        check("cancel_no_load", 32'(lv_seen), 0);
        cur_sec = 6'd50;
        tick();
        check("cancel_track_sec", 32'(set_sec), 50);

        // Inactivity timeout in EDIT_MIN: still editing after 29 idle cycles, gone after 30
        repeat (2) press(1, 0, 0, 0);
        check("to_field", 32'(edit_field), 2);
        repeat (29) tick();
        check("to_not_yet", 32'(editing), 1);
        tick();
        check("to_abort", 32'(editing), 0);
        check("to_no_load", 32'(lv_seen), 0);

        // COMMIT held off by load_ready; values frozen although cur changes
        set_cur(6, 7, 8, 9, 10, 11);
        tick();
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        repeat (6) press(1, 0, 0, 0);
        check("hold_lv", 32'(load_valid), 1);
        set_cur(20, 20, 20, 20, 11, 50);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_lv_stable", 32'(load_valid), 1);
            check("hold_hr_stable", 32'(set_hr24), 7);
            check("hold_day_stable", 32'(set_day), 9);
        end
        load_ready = 1'b1;
        tick();
        check("hold_release", 32'(load_valid), 0);
        load_ready = 1'b0;

        // Reset in the third COMMIT cycle drops the load without waiting for a clock
        repeat (7) press(1, 0, 0, 0);
        check("rstc_lv", 32'(load_valid), 1);
        tick(); tick();
        #3 rst = 1'b1;
        #1;
        check("rstc_lv_now", 32'(load_valid), 0);
        check("rstc_editing", 32'(editing), 0);
        check("rstc_hr", 32'(set_hr24), 0);
        check("rstc_year", 32'(set_year), 20);
        tick();
        rst = 1'b0;
        tick();
        check("rstc_after", 32'(load_valid), 0);

        // Holding inc for 10 cycles on MIN=0
        set_cur(1, 0, 0, 1, 1, 1);
        tick();
        repeat (2) press(1, 0, 0, 0);
        check("rep_start", 32'(set_min), 0);
        btn_inc = 1'b1;
        repeat (10) tick();
        btn_inc = 1'b0;
        tick(); tick();
`ifdef AUTO_REPEAT_EN
        check("rep_hold_min", 32'(set_min), 9);
`else
        check("rep_hold_min", 32'(set_min), 1);
`endif
        press(0, 0, 0, 1);
        check("rep_cancel", 32'(editing), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
